if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter QDEPTH, default 4: prefetch queue entries; power of two, >=2.
REQ-002 Parameter IMEM_AW, default 6: instruction memory word-address width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: fetch PC after reset; word aligned.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 StallF  input  1  decode not accepting; head entry held.
REQ-007 PCSrcD  input  2  redirect select: 0 sequential, 1 branch, 2 jump, 3 reserved (treated as 0).
REQ-008 PCBranchD  input  32  branch target.
REQ-009 jumpdst  input  32  jump target.
REQ-010 imem_addr  output  IMEM_AW  word address to instruction memory (combinational read).
REQ-011 imem_rd  input  32  instruction word returned the same cycle for imem_addr.
REQ-012 InstrF  output  32  head-of-queue instruction; 32'h0 when empty.
REQ-013 PCPlus4F  output  32  head-of-queue PC+4; 32'h0 when empty.
REQ-014 ValidF  output  1  head entry valid.

Function
REQ-015 Fetch PC register fpc SHALL drive imem_addr = fpc[IMEM_AW+1:2].
REQ-016 Push: when queue not full and no redirect, {imem_rd, fpc+4} SHALL be written at tail and fpc SHALL advance by 4.
REQ-017 Pop: when ValidF=1 and StallF=0, head SHALL advance by one entry.
REQ-018 Push and pop in the same cycle SHALL leave the occupancy count unchanged, including when full (pop frees the slot used by push).
REQ-019 Full (count==QDEPTH) without pop: no push; fpc held; imem_addr stable.
REQ-020 Empty: ValidF=0, InstrF=0, PCPlus4F=0; StallF has no effect.
REQ-021 Redirect (PCSrcD==1 or 2): queue SHALL be flushed (count=0); fpc SHALL load PCBranchD (1) or jumpdst (2); no push or pop that cycle.
REQ-022 Redirect SHALL take priority over push, pop and StallF.
REQ-023 Redirect latency: ValidF=0 the cycle after redirect; target instruction at head with ValidF=1 two cycles after redirect.
REQ-024 Head/tail pointers SHALL be log2(QDEPTH) bits, wrap modulo QDEPTH; count SHALL be log2(QDEPTH)+1 bits.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 Outputs SHALL be registered-state derived; no combinational path from StallF or PCSrcD to InstrF/PCPlus4F/ValidF.

Reset
REQ-027 reset SHALL set fpc=RESET_PC, head=tail=count=0, ValidF=0, InstrF=0, PCPlus4F=0.
REQ-028 reset SHALL override redirect, push and pop in the same cycle; reset mid-operation discards all entries.
REQ-029 First push SHALL occur the first cycle after reset deasserts.

Configuration
REQ-030 Macro IF_PREFETCH_PERF_EN: when defined, adds outputs perf_stall_cnt[31:0] (cycles with ValidF=1 and StallF=1) and perf_redirect_cnt[31:0] (redirect cycles), both reset to 0, saturating at 32'hFFFF_FFFF.
REQ-031 Without IF_PREFETCH_PERF_EN the counters and ports SHALL not exist; remaining behaviour identical.

Verification
REQ-032 Reset then run with StallF=0, imem word k = k: ValidF rises 1 cycle after reset release; InstrF=0,1,2,... one per cycle; PCPlus4F=4,8,12,...
REQ-033 Hold StallF=1 for 10 cycles, QDEPTH=4: queue fills after 4 pushes, imem_addr frozen at 4, InstrF stays 0; release -> 0,1,2,3,4 in consecutive cycles, no loss or duplicate.
REQ-034 PCSrcD=1, PCBranchD=32'h40 with queue full: next cycle ValidF=0, imem_addr=16; following cycle InstrF=mem[16], PCPlus4F=32'h44.
REQ-035 PCSrcD=2, jumpdst=32'h80 together with StallF=1 and reset=1: reset wins, fpc=RESET_PC; repeat without reset: jump taken, StallF ignored, queue flushed.
REQ-036 RESET_PC=32'hFFFF_FFF8, StallF=0: PCPlus4F sequence 32'hFFFF_FFFC, 0, 4.
REQ-037 With IF_PREFETCH_PERF_EN, 5 stall cycles with ValidF=1 plus 2 redirects -> perf_stall_cnt=5, perf_redirect_cnt=2.

Source files
------------

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch prefetch queue. A fetch PC (fpc) reads instruction memory
// combinationally and pushes {instruction, PC+4} into a small circular queue.
// Decode consumes from the head of the queue. A branch or jump redirect flushes
// the queue and reloads fpc.
//
// Parameters
//   QDEPTH    queue entries (power of two, >= 2)
//   IMEM_AW   instruction memory word-address width
//   RESET_PC  fetch PC after reset (word aligned)
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   StallF             decode not accepting; head entry is held
//   PCSrcD[1:0]        0 sequential, 1 branch, 2 jump, 3 treated as sequential
//   PCBranchD, jumpdst branch / jump targets
//   imem_addr, imem_rd instruction memory word address and returned word
//   InstrF, PCPlus4F   head-of-queue instruction and PC+4 (zero when empty)
//   ValidF             head entry valid
//
// Optional feature (macro IF_PREFETCH_PERF_EN)
//   perf_stall_cnt     cycles with ValidF=1 and StallF=1, saturating
//   perf_redirect_cnt  redirect cycles, saturating
// -----------------------------------------------------------------------------
module if_prefetch #(
   parameter int          QDEPTH   = 4,
   parameter int          IMEM_AW  = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               StallF,
   input  logic [1:0]         PCSrcD,
   input  logic [31:0]        PCBranchD,
   input  logic [31:0]        jumpdst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rd,
   output logic [31:0]        InstrF,
   output logic [31:0]        PCPlus4F,
`ifdef IF_PREFETCH_PERF_EN
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_redirect_cnt,
`endif
   output logic               ValidF
);

   localparam int PW = $clog2(QDEPTH);

   logic [31:0] instr_q [QDEPTH];
   logic [31:0] pc4_q   [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic [31:0]   fpc;

   logic redirect;
   logic valid;
   logic full;
   logic push;
   logic pop;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign redirect = (PCSrcD == 2'd1) || (PCSrcD == 2'd2);
   assign valid    = (count != '0);
   assign full     = (count == (PW+1)'(QDEPTH));
   // A pop frees the head slot, so a full queue can still accept a push.
   assign pop      = valid && !StallF && !redirect;
   assign push     = !redirect && (!full || pop);

   assign imem_addr = fpc[IMEM_AW+1:2];

   // Control state: pointers, occupancy and fetch PC
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc   <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         fpc   <= (PCSrcD == 2'd1) ? PCBranchD : jumpdst;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            fpc  <= fpc + 32'd4;
            tail <= tail + PW'(1);
         end
         if (pop)
            head <= head + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // Queue storage: no reset needed, contents are qualified by count
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         instr_q[tail] <= imem_rd;
         pc4_q[tail]   <= fpc + 32'd4;
      end
   end

   // Outputs depend only on registered state
   assign ValidF   = valid;
   assign InstrF   = valid ? instr_q[head] : 32'h0;
   assign PCPlus4F = valid ? pc4_q[head]   : 32'h0;

`ifdef IF_PREFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cnt    <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (valid && StallF)
            perf_stall_cnt <= sat_inc(perf_stall_cnt);
         if (redirect)
            perf_redirect_cnt <= sat_inc(perf_redirect_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
// Bench for if_prefetch: a queue-based reference model checked every cycle,
// plus directed literal checks of the documented fetch scenarios. A second
// instance with RESET_PC=32'hFFFF_FFF8 covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        StallF = 1'b0;
   logic [1:0]  PCSrcD = 2'd0;
   logic [31:0] PCBranchD = 32'h0;
   logic [31:0] jumpdst = 32'h0;
   logic [5:0]  imem_addr;
   logic [31:0] imem_rd;
   logic [31:0] InstrF, PCPlus4F;
   logic        ValidF;

   logic        reset2 = 1'b1;
   logic [5:0]  imem_addr2;
   logic [31:0] imem_rd2;
   logic [31:0] InstrF2, PCPlus4F2;
   logic        ValidF2;

`ifdef IF_PREFETCH_PERF_EN
   logic [31:0] perf_stall_cnt, perf_redirect_cnt;
   logic [31:0] perf_stall_cnt2, perf_redirect_cnt2;
`endif

   logic [31:0] mem [64];
   assign imem_rd  = mem[imem_addr];
   assign imem_rd2 = mem[imem_addr2];

   always #5 clk = ~clk;

   if_prefetch #(.QDEPTH(4), .IMEM_AW(6), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .StallF(StallF), .PCSrcD(PCSrcD),
      .PCBranchD(PCBranchD), .jumpdst(jumpdst), .imem_addr(imem_addr),
      .imem_rd(imem_rd), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
`ifdef IF_PREFETCH_PERF_EN
      .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt),
`endif
      .ValidF(ValidF));

   if_prefetch #(.QDEPTH(4), .IMEM_AW(6), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(reset2), .StallF(1'b0), .PCSrcD(2'd0),
      .PCBranchD(32'h0), .jumpdst(32'h0), .imem_addr(imem_addr2),
      .imem_rd(imem_rd2), .InstrF(InstrF2), .PCPlus4F(PCPlus4F2),
`ifdef IF_PREFETCH_PERF_EN
      .perf_stall_cnt(perf_stall_cnt2), .perf_redirect_cnt(perf_redirect_cnt2),
`endif
      .ValidF(ValidF2));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the queue as a list of {instr, pc+4} entries
   typedef struct {
      logic [31:0] ins;
      logic [31:0] p4;
   } ent_t;
   ent_t        q[$];
   logic [31:0] mpc;
   bit          started = 0;
   int unsigned mstall = 0;
   int unsigned mredir = 0;

   always @(posedge clk) begin
      bit was_full, do_pop;
      ent_t e;
      started = 1;
      if (reset) begin
         q.delete();
         mpc    = 32'h0;
         mstall = 0;
         mredir = 0;
      end else begin
         if (q.size() > 0 && StallF) mstall++;
         if (PCSrcD == 2'd1 || PCSrcD == 2'd2) begin
            mredir++;
            q.delete();
            mpc = (PCSrcD == 2'd1) ? PCBranchD : jumpdst;
         end else begin
            was_full = (q.size() == 4);
            do_pop   = (q.size() > 0) && !StallF;
            if (do_pop) void'(q.pop_front());
            if (!was_full || do_pop) begin
               e.ins = mem[mpc[7:2]];
               e.p4  = mpc + 32'd4;
               q.push_back(e);
               mpc = mpc + 32'd4;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         check("model_valid", {31'b0, ValidF}, {31'b0, (q.size() > 0)});
         check("model_addr", {26'b0, imem_addr}, {26'b0, mpc[7:2]});
         if (q.size() > 0) begin
            check("model_instr", InstrF, q[0].ins);
            check("model_pc4", PCPlus4F, q[0].p4);
         end else begin
            check("model_instr_empty", InstrF, 32'h0);
            check("model_pc4_empty", PCPlus4F, 32'h0);
         end
`ifdef IF_PREFETCH_PERF_EN
         check("model_perf_stall", perf_stall_cnt, mstall);
         check("model_perf_redir", perf_redirect_cnt, mredir);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = k;

      // Reset state
      tick(); tick();
      check("rst_valid", {31'b0, ValidF}, 32'h0);
      check("rst_instr", InstrF, 32'h0);
      check("rst_pc4", PCPlus4F, 32'h0);
      check("rst_addr", {26'b0, imem_addr}, 32'h0);

      // Free-running sequential fetch, both instances
      reset = 1'b0; reset2 = 1'b0;
      tick();
      check("seq_valid", {31'b0, ValidF}, 32'h1);
      check("seq_i0", InstrF, 32'd0);
      check("seq_p0", PCPlus4F, 32'd4);
      check("wrap_p0", PCPlus4F2, 32'hFFFF_FFFC);
      check("wrap_i0", InstrF2, 32'd62);
      tick();
      check("seq_i1", InstrF, 32'd1);
      check("seq_p1", PCPlus4F, 32'd8);
      check("wrap_p1", PCPlus4F2, 32'h0);
      check("wrap_i1", InstrF2, 32'd63);
      tick();
      check("seq_i2", InstrF, 32'd2);
      check("seq_p2", PCPlus4F, 32'd12);
      check("wrap_p2", PCPlus4F2, 32'd4);
      check("wrap_i2", InstrF2, 32'd0);

      // Stall from reset release: queue fills and fetch freezes
      reset = 1'b1; tick();
      reset = 1'b0; StallF = 1'b1;
      repeat (10) tick();
      check("stall_valid", {31'b0, ValidF}, 32'h1);
      check("stall_instr", InstrF, 32'd0);
      check("stall_addr", {26'b0, imem_addr}, 32'd4);
      StallF = 1'b0;
      #1 check("rel_i0", InstrF, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("rel_seq", InstrF, k);
      end

      // Branch with the queue full
      StallF = 1'b1;
      repeat (4) tick();
      PCSrcD = 2'd1; PCBranchD = 32'h40;
      tick();
      PCSrcD = 2'd0;
      check("br_valid", {31'b0, ValidF}, 32'h0);
      check("br_addr", {26'b0, imem_addr}, 32'd16);
      tick();
      check("br_valid2", {31'b0, ValidF}, 32'h1);
      check("br_instr", InstrF, 32'd16);
      check("br_pc4", PCPlus4F, 32'h44);

      // Reset wins over a simultaneous jump
      reset = 1'b1; PCSrcD = 2'd2; jumpdst = 32'h80; StallF = 1'b1;
      tick();
      check("rj_valid", {31'b0, ValidF}, 32'h0);
      check("rj_addr", {26'b0, imem_addr}, 32'h0);
      reset = 1'b0; PCSrcD = 2'd0;
      tick(); tick();
      // Jump while stalled with a partially filled queue
      PCSrcD = 2'd2;
      tick();
      check("jmp_valid", {31'b0, ValidF}, 32'h0);
      check("jmp_addr", {26'b0, imem_addr}, 32'd32);
      PCSrcD = 2'd0; StallF = 1'b0;
      tick();
      check("jmp_instr", InstrF, 32'd32);
      check("jmp_pc4", PCPlus4F, 32'h84);

`ifdef IF_PREFETCH_PERF_EN
      // 5 stall cycles with a valid head plus 2 redirects
      reset = 1'b1; tick();
      reset = 1'b0; StallF = 1'b0; tick();
      StallF = 1'b1; repeat (5) tick();
      StallF = 1'b0; PCSrcD = 2'd1; PCBranchD = 32'h10; tick();
      PCSrcD = 2'd2; jumpdst = 32'h20; tick();
      PCSrcD = 2'd0; tick();
      check("perf_stall", perf_stall_cnt, 32'd5);
      check("perf_redir", perf_redirect_cnt, 32'd2);
`endif

      // Mixed directed pattern, checked by the model every cycle
      for (int i = 0; i < 80; i++) begin
         StallF    = (i % 3 == 1) || (i % 11 > 7);
         PCBranchD = 32'(((i * 7) % 64) * 4);
         jumpdst   = 32'(((i * 13) % 64) * 4);
         if (i % 17 == 5)       PCSrcD = 2'd1;
         else if (i % 23 == 11) PCSrcD = 2'd2;
         else if (i % 7 == 3)   PCSrcD = 2'd3;
         else                   PCSrcD = 2'd0;
         reset = (i == 60);
         tick();
      end
      PCSrcD = 2'd0; StallF = 1'b0; reset = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
